// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and flag bit positions for seq_alu.
// The SEQ_ALU_MULDIV_EN build of seq_alu also uses the multi-cycle opcodes here.
package alu_pkg;

    localparam logic [4:0] OP_PASS_A = 5'd0;
    localparam logic [4:0] OP_PASS_B = 5'd1;
    localparam logic [4:0] OP_NOT_A  = 5'd2;
    localparam logic [4:0] OP_NOT_B  = 5'd3;
    localparam logic [4:0] OP_ADD    = 5'd4;
    localparam logic [4:0] OP_ADC    = 5'd5;
    localparam logic [4:0] OP_SUB    = 5'd6;
    localparam logic [4:0] OP_AND    = 5'd7;
    localparam logic [4:0] OP_OR     = 5'd8;
    localparam logic [4:0] OP_XOR    = 5'd9;
    localparam logic [4:0] OP_NAND   = 5'd10;
    localparam logic [4:0] OP_LSL    = 5'd11;
    localparam logic [4:0] OP_LSR    = 5'd12;
    localparam logic [4:0] OP_ASR    = 5'd13;
    localparam logic [4:0] OP_ROL    = 5'd14;
    localparam logic [4:0] OP_ROR    = 5'd15;
    localparam logic [4:0] OP_MUL    = 5'd16;
    localparam logic [4:0] OP_DIV    = 5'd17;
    localparam logic [4:0] OP_MOD    = 5'd18;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_O = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        EXEC = 2'd2
    } state_t;

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
    endfunction

    function automatic logic is_divmod(input logic [4:0] op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative engine: shift-add multiply and restoring divide run side by side,
// one bit per step, for an effective width of WIDTH or WIDTH/2.
module seq_alu_muldiv #(
    parameter int WIDTH = 16
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               load,
    input  logic               step,
    input  logic               half,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder
);
    localparam int H  = WIDTH / 2;
    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]      count_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [WIDTH-1:0]   quo_reg;
    logic [WIDTH-1:0]   rem_reg;
    logic [WIDTH-1:0]   dvsr_reg;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;

    // The remainder stays below the divisor, so bit WIDTH of the trial
    // subtraction is a clean borrow indicator.
    assign shifted = {rem_reg, quo_reg[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvsr_reg};

    always_ff @(posedge Clock) begin
        if (Reset) begin
            count_reg  <= '0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            quo_reg    <= '0;
            rem_reg    <= '0;
            dvsr_reg   <= '0;
        end else if (load) begin
            count_reg  <= half ? CW'(H - 1) : CW'(WIDTH - 1);
            acc_reg    <= '0;
            mcand_reg  <= {{WIDTH{1'b0}}, a};
            mplier_reg <= b;
            // Half-width dividends are left-aligned so the MSB-first walk
            // always starts from bit WIDTH-1.
            quo_reg    <= half ? (a << H) : a;
            rem_reg    <= '0;
            dvsr_reg   <= b;
        end else if (step) begin
            if (count_reg != '0) begin
                count_reg <= count_reg - CW'(1);
            end
            if (mplier_reg[0]) begin
                acc_reg <= acc_reg + mcand_reg;
            end
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            if (!trial[WIDTH]) begin
                rem_reg <= trial[WIDTH-1:0];
                quo_reg <= {quo_reg[WIDTH-2:0], 1'b1};
            end else begin
                rem_reg <= shifted[WIDTH-1:0];
                quo_reg <= {quo_reg[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign done      = (count_reg == '0);
    assign product   = acc_reg;
    assign quotient  = quo_reg;
    assign remainder = rem_reg;

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with Start/Ready/Valid handshake and Z/C/N/O flags register.
// Define SEQ_ALU_MULDIV_EN to build the iterative MUL/DIV/MOD ops (16-18).
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    output logic             Ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       Op,
    input  logic             Half,
    input  logic             WF,
    output logic [WIDTH-1:0] Result,
    output logic             Valid,
    output logic [3:0]       FlagsOut
);
    localparam int H = WIDTH / 2;
    localparam logic [WIDTH-1:0] TOP_FULL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] TOP_HALF = {{(WIDTH-H){1'b0}}, 1'b1, {(H-1){1'b0}}};

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [4:0]       op_reg;
    logic             half_reg, wf_reg;
    logic [WIDTH-1:0] result_reg;
    logic             valid_reg;
    logic [3:0]       flags_reg, flags_next;

    logic             accept, exec_fire;
    logic [WIDTH-1:0] mask_in, mask_reg, top_bit;
    logic             a_msb, b_msb, r_msb, cin, adc_cin;
    logic [WIDTH:0]   sum_add, diff_sub;
    logic             add_carry, sub_borrow;
    logic [WIDTH-1:0] res_raw, res_w;
    logic             legal, c_new, o_new, keep_n, arith;

    assign mask_in  = {{(WIDTH-H){~Half}}, {H{1'b1}}};
    assign mask_reg = {{(WIDTH-H){~half_reg}}, {H{1'b1}}};
    assign top_bit  = half_reg ? TOP_HALF : TOP_FULL;

`ifdef SEQ_ALU_MULDIV_EN
    logic               go_iter, b_zero_in, dz_reg;
    logic               eng_load, eng_step, eng_done;
    logic [2*WIDTH-1:0] eng_product;
    logic [WIDTH-1:0]   eng_quotient, eng_remainder;
    logic [WIDTH-1:0]   prod_lo, prod_hi;

    // Divide-by-zero never enters the iterative path.
    assign b_zero_in = ((B & mask_in) == '0);
    assign go_iter   = is_muldiv(Op) && !(is_divmod(Op) && b_zero_in);
    assign prod_lo   = half_reg ? {{(WIDTH-H){1'b0}}, eng_product[H-1:0]} : eng_product[WIDTH-1:0];
    assign prod_hi   = half_reg ? {{(WIDTH-H){1'b0}}, eng_product[WIDTH-1:H]} : eng_product[2*WIDTH-1:WIDTH];

    seq_alu_muldiv #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .Clock     (Clock),
        .Reset     (Reset),
        .load      (eng_load),
        .step      (eng_step),
        .half      (Half),
        .a         (A & mask_in),
        .b         (B & mask_in),
        .done      (eng_done),
        .product   (eng_product),
        .quotient  (eng_quotient),
        .remainder (eng_remainder)
    );
`endif

    // FSM state register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
`ifdef SEQ_ALU_MULDIV_EN
                    state_next = go_iter ? ITER : EXEC;
`else
                    state_next = EXEC;
`endif
                end
            end
`ifdef SEQ_ALU_MULDIV_EN
            ITER: begin
                if (eng_done) begin
                    state_next = EXEC;
                end
            end
`endif
            EXEC:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs; Ready stays low through the Valid cycle.
    always_comb begin
        Ready     = (state_reg == IDLE) && !valid_reg;
        accept    = Start && Ready;
        exec_fire = (state_reg == EXEC);
`ifdef SEQ_ALU_MULDIV_EN
        eng_load  = accept && go_iter;
        eng_step  = (state_reg == ITER);
`endif
    end

    assign cin        = flags_reg[FLAG_C];
    assign adc_cin    = (op_reg == OP_ADC) ? cin : 1'b0;
    assign sum_add    = {1'b0, a_reg} + {1'b0, b_reg} + {{WIDTH{1'b0}}, adc_cin};
    assign diff_sub   = {1'b0, a_reg} - {1'b0, b_reg};
    assign add_carry  = half_reg ? sum_add[H] : sum_add[WIDTH];
    assign sub_borrow = half_reg ? diff_sub[H] : diff_sub[WIDTH];
    assign a_msb      = |(a_reg & top_bit);
    assign b_msb      = |(b_reg & top_bit);

    always_comb begin
        res_raw    = '0;
        legal      = 1'b1;
        c_new      = flags_reg[FLAG_C];
        o_new      = flags_reg[FLAG_O];
        keep_n     = 1'b0;
        arith      = 1'b0;
        case (op_reg)
            OP_PASS_A: res_raw = a_reg;
            OP_PASS_B: res_raw = b_reg;
            OP_NOT_A:  res_raw = ~a_reg;
            OP_NOT_B:  res_raw = ~b_reg;
            OP_ADD, OP_ADC: begin
                res_raw = sum_add[WIDTH-1:0];
                c_new   = add_carry;
                arith   = 1'b1;
            end
            OP_SUB: begin
                res_raw = diff_sub[WIDTH-1:0];
                c_new   = sub_borrow;
                arith   = 1'b1;
            end
            OP_AND:  res_raw = a_reg & b_reg;
            OP_OR:   res_raw = a_reg | b_reg;
            OP_XOR:  res_raw = a_reg ^ b_reg;
            OP_NAND: res_raw = ~(a_reg & b_reg);
            OP_LSL: begin
                res_raw = a_reg << 1;
                c_new   = a_msb;
            end
            OP_LSR: begin
                res_raw = a_reg >> 1;
                c_new   = a_reg[0];
            end
            OP_ASR: begin
                res_raw = (a_reg >> 1) | (a_msb ? top_bit : '0);
                c_new   = a_reg[0];
                keep_n  = 1'b1;
            end
            OP_ROL: begin
                res_raw = {a_reg[WIDTH-2:0], cin};
                c_new   = a_msb;
            end
            OP_ROR: begin
                res_raw = (a_reg >> 1) | (cin ? top_bit : '0);
                c_new   = a_reg[0];
            end
`ifdef SEQ_ALU_MULDIV_EN
            OP_MUL: begin
                res_raw = prod_lo;
                c_new   = |prod_hi;
                o_new   = |prod_hi;
            end
            OP_DIV: begin
                res_raw = dz_reg ? '1 : eng_quotient;
                c_new   = dz_reg;
            end
            OP_MOD: begin
                res_raw = dz_reg ? a_reg : eng_remainder;
                c_new   = dz_reg;
            end
`endif
            default: legal = 1'b0;
        endcase
        res_w = res_raw & mask_reg;
        r_msb = |(res_w & top_bit);
        if (arith) begin
            o_new = c_new ^ a_msb ^ b_msb ^ r_msb;
        end
        flags_next         = '0;
        flags_next[FLAG_Z] = (res_w == '0);
        flags_next[FLAG_C] = c_new;
        flags_next[FLAG_N] = keep_n ? flags_reg[FLAG_N] : r_msb;
        flags_next[FLAG_O] = o_new;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= '0;
            half_reg   <= 1'b0;
            wf_reg     <= 1'b0;
            result_reg <= '0;
            valid_reg  <= 1'b0;
            flags_reg  <= '0;
`ifdef SEQ_ALU_MULDIV_EN
            dz_reg     <= 1'b0;
`endif
        end else begin
            valid_reg <= exec_fire;
            if (accept) begin
                a_reg    <= A & mask_in;
                b_reg    <= B & mask_in;
                op_reg   <= Op;
                half_reg <= Half;
                wf_reg   <= WF;
`ifdef SEQ_ALU_MULDIV_EN
                dz_reg   <= b_zero_in;
`endif
            end
            if (exec_fire) begin
                result_reg <= res_w;
                if (wf_reg && legal) begin
                    flags_reg <= flags_next;
                end
            end
        end
    end

    assign Result   = result_reg;
    assign Valid    = valid_reg;
    assign FlagsOut = flags_reg;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: expectations are queued at acceptance and
// popped on Valid. Follows SEQ_ALU_MULDIV_EN for ops 16-18.
module tb_seq_alu;
    localparam int WIDTH = 16;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start;
    logic        Ready;
    logic [15:0] A, B;
    logic [4:0]  Op;
    logic        Half, WF;
    logic [15:0] Result;
    logic        Valid;
    logic [3:0]  FlagsOut;

    seq_alu #(.WIDTH(WIDTH)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Start    (Start),
        .Ready    (Ready),
        .A        (A),
        .B        (B),
        .Op       (Op),
        .Half     (Half),
        .WF       (WF),
        .Result   (Result),
        .Valid    (Valid),
        .FlagsOut (FlagsOut)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [4:0]  op;
        logic [15:0] res;
        logic [3:0]  flags;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         total = 0;
    int         bad = 0;
    logic [3:0] mflags = 4'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic msbw(input longint x, input int w);
        return ((x >> (w - 1)) & 64'd1) != 0;
    endfunction

    // Reference model: effective-width arithmetic on wide integers.
    function automatic void model(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                                  input logic half, input logic wf,
                                  output logic [15:0] res, output int lat);
        int     w = half ? 8 : 16;
        longint mask = (longint'(1) << w) - 1;
        longint ma = longint'(a) & mask;
        longint mb = longint'(b) & mask;
        longint r = 0;
        longint t;
        logic   cin = mflags[2];
        logic   c = mflags[2];
        logic   o = mflags[0];
        logic   legal = 1'b1;
        logic   keepn = 1'b0;
        logic   arith = 1'b0;
        lat = 1;
        case (op)
            5'd0: r = ma;
            5'd1: r = mb;
            5'd2: r = ~ma & mask;
            5'd3: r = ~mb & mask;
            5'd4, 5'd5: begin
                t = ma + mb + ((op == 5'd5) ? longint'(cin) : 0);
                c = ((t >> w) & 1) != 0;
                r = t & mask;
                arith = 1'b1;
            end
            5'd6: begin
                c = (ma < mb);
                r = (ma - mb) & mask;
                arith = 1'b1;
            end
            5'd7:  r = ma & mb;
            5'd8:  r = ma | mb;
            5'd9:  r = ma ^ mb;
            5'd10: r = ~(ma & mb) & mask;
            5'd11: begin c = msbw(ma, w); r = (ma << 1) & mask; end
            5'd12: begin c = ma[0]; r = ma >> 1; end
            5'd13: begin c = ma[0]; r = (ma >> 1) | (longint'(msbw(ma, w)) << (w - 1)); keepn = 1'b1; end
            5'd14: begin c = msbw(ma, w); r = ((ma << 1) | longint'(cin)) & mask; end
            5'd15: begin c = ma[0]; r = (ma >> 1) | (longint'(cin) << (w - 1)); end
`ifdef SEQ_ALU_MULDIV_EN
            5'd16: begin
                t = ma * mb;
                r = t & mask;
                c = (t >> w) != 0;
                o = c;
                lat = w + 1;
            end
            5'd17, 5'd18: begin
                if (mb == 0) begin
                    r = (op == 5'd17) ? mask : ma;
                    c = 1'b1;
                end else begin
                    r = (op == 5'd17) ? (ma / mb) : (ma % mb);
                    c = 1'b0;
                    lat = w + 1;
                end
            end
`endif
            default: begin
                legal = 1'b0;
                r = 0;
            end
        endcase
        if (arith) o = c ^ msbw(ma, w) ^ msbw(mb, w) ^ msbw(r, w);
        if (legal && wf) mflags = {r == 0, c, keepn ? mflags[1] : msbw(r, w), o};
        res = r[15:0];
    endfunction

    // hold=1 keeps Start asserted (with different operands) until Valid.
    task automatic do_op(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic half, input logic wf, input logic hold);
        logic [15:0] er;
        int          lat;
        int          edges;
        int          waitc;
        exp_t        e;
        @(negedge Clock);
        waitc = 0;
        while (!Ready && waitc < 100) begin
            @(negedge Clock);
            waitc++;
        end
        if (!Ready) begin
            check_eq("ready_wait", Ready, 1);
            return;
        end
        Op = op; A = a; B = b; Half = half; WF = wf; Start = 1'b1;
        @(posedge Clock);
        model(op, a, b, half, wf, er, lat);
        e.op = op; e.res = er; e.flags = mflags;
        sb_q.push_back(e);
        #1;
        check_eq("ready_drop", Ready, 0);
        if (hold) begin
            Op = 5'd4;
            A = ~a;
        end else begin
            Start = 1'b0;
        end
        edges = 0;
        while (!Valid && edges < 64) begin
            @(posedge Clock);
            #1;
            edges++;
        end
        Start = 1'b0;
        check_eq("latency", edges, lat);
        @(posedge Clock);
        #1;
        check_eq("valid_pulse", Valid, 0);
        check_eq("ready_back", Ready, 1);
    endtask

    always @(negedge Clock) begin
        if (!Reset && Valid) begin
            if (sb_q.size() == 0) begin
                check_eq("spurious_valid", Valid, 0);
            end else begin
                mon_e = sb_q.pop_front();
                $display("txn op=%0d result=%h flags=%b want=%h/%b",
                         mon_e.op, Result, FlagsOut, mon_e.res, mon_e.flags);
                check_eq("result", Result, mon_e.res);
                check_eq("flags", FlagsOut, mon_e.flags);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        Reset = 1'b1; Start = 1'b1; Op = 5'd4; A = 16'h0001; B = 16'h0001; Half = 1'b0; WF = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        check_eq("rst_result", Result, 0);
        check_eq("rst_valid", Valid, 0);
        check_eq("rst_flags", FlagsOut, 0);
        check_eq("rst_ready", Ready, 1);
        @(negedge Clock);
        Reset = 1'b0; Start = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        check_eq("start_in_reset", Valid, 0);

        do_op(5'd4, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0);
        check_eq("plan_add_res", Result, 16'h0000);
        check_eq("plan_add_flags", FlagsOut, 4'b1100);

        do_op(5'd6, 16'h0040, 16'h0041, 1'b1, 1'b1, 1'b0);
        check_eq("plan_hsub_res", Result, 16'h00FF);
        check_eq("plan_hsub_flags", FlagsOut, 4'b0110);

        // Start held high for the whole operation must not launch a second op.
        do_op(5'd16, 16'h0100, 16'h0100, 1'b0, 1'b1, 1'b1);
        check_eq("plan_mul_res", Result, 16'h0000);
`ifdef SEQ_ALU_MULDIV_EN
        check_eq("plan_mul_flags", FlagsOut, 4'b1101);
`else
        check_eq("plan_mul_flags", FlagsOut, 4'b0110);
`endif

        do_op(5'd17, 16'd100, 16'd7, 1'b0, 1'b1, 1'b0);
`ifdef SEQ_ALU_MULDIV_EN
        check_eq("plan_div", Result, 16'd14);
`endif
        do_op(5'd18, 16'd100, 16'd7, 1'b0, 1'b1, 1'b0);
`ifdef SEQ_ALU_MULDIV_EN
        check_eq("plan_mod", Result, 16'd2);
`endif
        do_op(5'd17, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0);
`ifdef SEQ_ALU_MULDIV_EN
        check_eq("plan_div0", Result, 16'hFFFF);
`endif

        do_op(5'd4, 16'h8000, 16'h8001, 1'b0, 1'b1, 1'b0);
        check_eq("preset_flags", FlagsOut, 4'b0101);
        do_op(5'd20, 16'h5555, 16'h3333, 1'b0, 1'b1, 1'b0);
        check_eq("illegal_res", Result, 16'h0000);
        check_eq("illegal_flags", FlagsOut, 4'b0101);

        do_op(5'd9, 16'hA5A5, 16'h0FF0, 1'b0, 1'b1, 1'b1);
        do_op(5'd14, 16'h8001, 16'h0000, 1'b0, 1'b1, 1'b0);
        do_op(5'd15, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0);
        do_op(5'd13, 16'h0081, 16'h0000, 1'b1, 1'b1, 1'b0);
        do_op(5'd5, 16'h00FF, 16'h0000, 1'b1, 1'b1, 1'b0);
        do_op(5'd16, 16'h00F3, 16'h00C7, 1'b1, 1'b1, 1'b0);
        do_op(5'd18, 16'h00C8, 16'h000D, 1'b1, 1'b1, 1'b0);
        do_op(5'd17, 16'hFFFF, 16'h00FF, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            do_op(5'($urandom_range(0, 20)), 16'($urandom), 16'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'b0);
        end

`ifdef SEQ_ALU_MULDIV_EN
        // Reset in the middle of a multiply: no Valid may follow.
        @(negedge Clock);
        Op = 5'd16; A = 16'h0100; B = 16'h0100; Half = 1'b0; WF = 1'b1; Start = 1'b1;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        repeat (5) @(posedge Clock);
        @(negedge Clock);
        check_eq("iter_ready", Ready, 0);
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        check_eq("abort_result", Result, 0);
        check_eq("abort_valid", Valid, 0);
        check_eq("abort_flags", FlagsOut, 0);
        check_eq("abort_ready", Ready, 1);
        @(negedge Clock);
        Reset = 1'b0;
        mflags = 4'b0;
        repeat (25) @(posedge Clock);
        do_op(5'd4, 16'h0001, 16'h0002, 1'b0, 1'b1, 1'b0);
        check_eq("after_abort", Result, 16'h0003);
`endif

        repeat (3) @(posedge Clock);
        check_eq("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
